// File: rtl/bmul_arbiter.sv
// Purpose: two-requester round-robin arbiter and sequencer in front of one shared bmul 8.8 multiplier.
// Latency: ack one edge after a request is sampled in IDLE; done k edges later (k = bmul latency, capped at TIMEOUT).
// Backpressure: requests wait (held high) until acked; requests are not sampled while BUSY or DONE.
module bmul_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic        err,
  output logic        busy,
  output logic [7:0]  mul_a_int,
  output logic [7:0]  mul_a_dec,
  output logic [7:0]  mul_b_int,
  output logic [7:0]  mul_b_dec,
  output logic        mul_in_rdy,
  input  logic [7:0]  mul_res_int1,
  input  logic [7:0]  mul_res_int2,
  input  logic [7:0]  mul_res_dec1,
  input  logic [7:0]  mul_res_dec2,
  input  logic        mul_res_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operand bundle in the same bit order as {a, b} on the requester side.
  typedef struct packed {
    logic [7:0] a_int;
    logic [7:0] a_dec;
    logic [7:0] b_int;
    logic [7:0] b_dec;
  } opnd_t;

  // Last counter value of a BUSY window; reaching it without a result aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last;       // id of the most recent grant; the other side wins a tie
  logic       owner;      // id of the transaction currently in flight
  logic [7:0] cnt;        // BUSY cycles elapsed for the current transaction
  opnd_t      opnd_q;
  opnd_t      opnd_sel;
  logic       grant;
  logic       grant_id;
  logic       res_hit;
  logic       to_hit;
  logic       finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a grant leaves IDLE, a result or timeout leaves BUSY, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req0 || req1) state_nxt = S_BUSY;
      S_BUSY:  if (mul_res_rdy || (cnt == CNT_LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: arbitration in IDLE, completion detection in BUSY, busy flag
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    res_hit  = 1'b0;
    to_hit   = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        grant    = req0 | req1;
        // On contention alternate away from the last grant; otherwise take whoever asks.
        grant_id = (req0 && req1) ? ~last : req1;
      end
      S_BUSY: begin
        busy    = 1'b1;
        res_hit = mul_res_rdy;
        // A result arriving on the timeout cycle takes priority over the abort.
        to_hit  = ~mul_res_rdy && (cnt == CNT_LAST);
      end
      S_DONE: busy = 1'b1;
      default: ;
    endcase
  end

  assign finish   = res_hit | to_hit;
  assign opnd_sel = grant_id ? opnd_t'({a1, b1}) : opnd_t'({a0, b0});

  // Grant side: pointer, owner, operand latch, ack pulses and multiplier start/hold
  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      opnd_q     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mul_in_rdy <= 1'b0;
    end else begin
      ack0 <= grant & ~grant_id;
      ack1 <= grant & grant_id;
      if (grant) begin
        last       <= grant_id;
        owner      <= grant_id;
        opnd_q     <= opnd_sel;
        mul_in_rdy <= 1'b1;
      end else if (finish) begin
        mul_in_rdy <= 1'b0;
      end
    end
  end

  // Timeout counter: cleared on grant, counts every BUSY cycle
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (grant)           cnt <= '0;
    else if (state == S_BUSY) cnt <= cnt + 8'd1;
  end

  // Completion side: done pulse to the owner, result/err held until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      done0 <= finish & ~owner;
      done1 <= finish & owner;
      if (res_hit) begin
        res <= {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2};
        err <= 1'b0;
      end else if (to_hit) begin
        res <= '0;
        err <= 1'b1;
      end
    end
  end

  assign mul_a_int = opnd_q.a_int;
  assign mul_a_dec = opnd_q.a_dec;
  assign mul_b_int = opnd_q.b_int;
  assign mul_b_dec = opnd_q.b_dec;

endmodule

// File: tb/tb_bmul_arbiter.sv
// Purpose: self-checking bench for bmul_arbiter with a behavioural bmul model and a result scoreboard.
// Latency: model bmul raises res_rdy a programmable number of in_rdy cycles after start (0 = never).
// Backpressure: requests are held until ack and dropped on the ack cycle.
module tb_bmul_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, done0, done1;
  logic [31:0] res;
  logic        err, busy;
  logic [7:0]  mul_a_int, mul_a_dec, mul_b_int, mul_b_dec;
  logic        mul_in_rdy;
  logic [7:0]  mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2;
  logic        mul_res_rdy;

  bmul_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .mul_a_int(mul_a_int), .mul_a_dec(mul_a_dec),
    .mul_b_int(mul_b_int), .mul_b_dec(mul_b_dec),
    .mul_in_rdy(mul_in_rdy),
    .mul_res_int1(mul_res_int1), .mul_res_int2(mul_res_int2),
    .mul_res_dec1(mul_res_dec1), .mul_res_dec2(mul_res_dec2),
    .mul_res_rdy(mul_res_rdy)
  );

  always #5 clk = ~clk;

  // Behavioural bmul: product of the presented operands, ready after mdl_lat in_rdy cycles
  int          mdl_lat;
  int          mcnt;
  logic        stale;
  logic [31:0] prod;

  always @(posedge clk) begin
    if (!mul_in_rdy) mcnt <= 0;
    else             mcnt <= mcnt + 1;
  end

  assign prod = {16'h0, mul_a_int, mul_a_dec} * {16'h0, mul_b_int, mul_b_dec};
  assign {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = prod;
  assign mul_res_rdy = stale | (mul_in_rdy && (mdl_lat != 0) && (mcnt == mdl_lat - 1));

  // Scoreboard
  int          n_chk;
  int          n_fail;
  logic        gnt_q[$];
  logic [33:0] res_q[$];   // {id, err, res}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected grant on every ack and the expected completion on every done
  always @(negedge clk) begin
    logic        eg;
    logic [33:0] er;
    if (ack0 | ack1) begin
      if (gnt_q.size() == 0) chk("unexpected ack", {62'h0, ack0, ack1}, 64'h0);
      else begin
        eg = gnt_q.pop_front();
        chk("grant id", {62'h0, ack0, ack1}, {62'h0, ~eg, eg});
      end
    end
    if (done0 | done1) begin
      if (res_q.size() == 0) chk("unexpected done", {62'h0, done0, done1}, 64'h0);
      else begin
        er = res_q.pop_front();
        chk("done result", {29'h0, done0, done1, err, res}, {29'h0, ~er[33], er[33], er[32], er[31:0]});
      end
    end
  end

  task automatic wait_ack(input bit id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) begin
        got = 1'b1;
        break;
      end
    end
    chk(id ? "ack1 seen" : "ack0 seen", {63'h0, got}, 64'h1);
  endtask

  // One isolated transaction from IDLE; checks operands, in_rdy window, done timing and return to IDLE
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b, input int lat,
                       input logic [31:0] eres, input bit eerr, input int ecyc, input bit stale_done);
    int n;
    mdl_lat = lat;
    if (id) begin a1 = a; b1 = b; end
    else    begin a0 = a; b0 = b; end
    gnt_q.push_back(id);
    res_q.push_back({id, eerr, eres});
    if (id) req1 = 1'b1; else req0 = 1'b1;
    wait_ack(id);
    chk("operands out", {32'h0, mul_a_int, mul_a_dec, mul_b_int, mul_b_dec}, {32'h0, a, b});
    chk("busy on ack", {63'h0, busy}, 64'h1);
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    if (mul_in_rdy) n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!mul_in_rdy) break;
      n++;
    end
    chk("in_rdy cycles", 64'(n), 64'(ecyc));
    chk("done on in_rdy drop", {63'h0, id ? done1 : done0}, 64'h1);
    chk("busy in DONE", {63'h0, busy}, 64'h1);
    stale = stale_done;
    @(negedge clk);
    stale = 1'b0;
    chk("idle after DONE", {61'h0, busy, done0, done1}, 64'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (res_q.size() == 0) break;
      @(negedge clk);
    end
    chk("result queue drained", 64'(res_q.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack;
    clk = 1'b0; rst = 1'b1; stale = 1'b0; mdl_lat = 3;
    n_chk = 0; n_fail = 0;
    // Contention setup: both requests held from reset
    req0 = 1'b1; req1 = 1'b1;
    a0 = 16'h0200; b0 = 16'h0200; a1 = 16'h0180; b1 = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    chk("reset ctrl", {57'h0, ack0, ack1, done0, done1, err, busy, mul_in_rdy}, 64'h0);
    chk("reset res", {32'h0, res}, 64'h0);
    chk("reset opnd", {32'h0, mul_a_int, mul_a_dec, mul_b_int, mul_b_dec}, 64'h0);

    // Contention: grants alternate 0,1,0,1, each result matches its own operands
    for (int i = 0; i < 2; i++) begin
      gnt_q.push_back(1'b0); res_q.push_back({1'b0, 1'b0, 32'h0004_0000});
      gnt_q.push_back(1'b1); res_q.push_back({1'b1, 1'b0, 32'h0003_0000});
    end
    rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack0 | ack1) nack++;
      if (nack == 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contention acks", 64'(nack), 64'd4);
    drain();
    @(negedge clk);
    @(negedge clk);

    // Single op: 2.0 * 2.0, three-cycle multiplier
    do_op(1'b0, 16'h0200, 16'h0200, 3, 32'h0004_0000, 1'b0, 3, 1'b0);
    // Minimum latency, fractional pass-through
    do_op(1'b1, 16'h0101, 16'h0100, 1, 32'h0001_0100, 1'b0, 1, 1'b0);
    // Full-scale operands, no saturation; stale ready pulsed during DONE
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 2, 32'hFFFE_0001, 1'b0, 2, 1'b1);
    // Timeout: multiplier never answers
    do_op(1'b0, 16'h0300, 16'h0100, 0, 32'h0000_0000, 1'b1, 8, 1'b0);
    // Coincidence: result on the timeout cycle wins
    do_op(1'b1, 16'h0180, 16'h0200, 8, 32'h0003_0000, 1'b0, 8, 1'b0);

    // Stale ready in IDLE
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    chk("stale idle", {60'h0, busy, done0, done1, mul_in_rdy}, 64'h0);
    @(negedge clk);
    chk("stale idle after", {60'h0, busy, done0, done1, mul_in_rdy}, 64'h0);

    // Reset mid-BUSY: silent abort, then req0 wins the first contention
    mdl_lat = 0;
    a1 = 16'h0500; b1 = 16'h0200;
    gnt_q.push_back(1'b1);
    req1 = 1'b1;
    wait_ack(1'b1);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-busy reset ctrl", {57'h0, ack0, ack1, done0, done1, err, busy, mul_in_rdy}, 64'h0);
    chk("mid-busy reset data", {res, mul_a_int, mul_a_dec, mul_b_int, mul_b_dec}, 64'h0);
    mdl_lat = 3;
    a0 = 16'h0200; b0 = 16'h0200; a1 = 16'h0180; b1 = 16'h0200;
    req0 = 1'b1; req1 = 1'b1;
    gnt_q.push_back(1'b0); res_q.push_back({1'b0, 1'b0, 32'h0004_0000});
    gnt_q.push_back(1'b1); res_q.push_back({1'b1, 1'b0, 32'h0003_0000});
    @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b0);
    req0 = 1'b0;
    wait_ack(1'b1);
    req1 = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("grant queue drained", 64'(gnt_q.size()), 64'h0);
    chk("final idle", {62'h0, busy, mul_in_rdy}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
